// File: rtl/o_ddr_gearbox_pkg.sv
// o_ddr_gearbox_pkg: shared state enum, width limit and slice-counter width helper for o_ddr_gearbox
package o_ddr_gearbox_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int O_DDR_GEARBOX_MAX_WIDTH = 16;
  function automatic int o_ddr_gearbox_cnt_w(input int width);
    return (width / 2 > 1) ? $clog2(width / 2) : 1;
  endfunction
endpackage

// File: rtl/o_ddr_gearbox_hold.sv
// o_ddr_gearbox_hold: one-word holding register (clk, rst, wr stores d and sets hold_v, clr drops hold_v; wr wins)
module o_ddr_gearbox_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] hold,
  output logic             hold_v
);
  always_ff @(posedge clk)
    if (rst) begin
      hold   <= '0;
      hold_v <= 1'b0;
    end else if (wr) begin
      hold   <= d;
      hold_v <= 1'b1;
    end else if (clr) begin
      hold_v <= 1'b0;
    end
endmodule

// File: rtl/o_ddr_gearbox.sv
// o_ddr_gearbox: WIDTH-bit D/D_VALID/D_READY words to LSB-first 2-bit Q/OE slices on C (sync reset R), UNDERRUN pulse; UNDERRUN_CNT[7:0] added with O_DDR_GEARBOX_UNDERRUN_CNT_EN
module o_ddr_gearbox
  import o_ddr_gearbox_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VALID,
  output logic             D_READY,
  output logic [1:0]       Q,
  output logic             OE,
`ifdef O_DDR_GEARBOX_UNDERRUN_CNT_EN
  output logic             UNDERRUN,
  output logic [7:0]       UNDERRUN_CNT
`else
  output logic             UNDERRUN
`endif
);
  localparam int N  = WIDTH / 2;
  localparam int CW = o_ddr_gearbox_cnt_w(WIDTH);
  if (WIDTH % 2 != 0 || WIDTH < 2 || WIDTH > O_DDR_GEARBOX_MAX_WIDTH)
    $error("o_ddr_gearbox: WIDTH must be even and within 2..16");
  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n, hold;
  logic [CW-1:0]    cnt, cnt_n;
  logic             hold_v, accept, load, avail, und_n;
  assign D_READY = !hold_v && !R;
  assign accept  = D_VALID && D_READY;
  assign load    = state == IDLE || cnt == CW'(N - 1);
  assign avail   = hold_v || accept;
  assign Q       = sr[1:0];
  assign OE      = state == SHIFT;
  o_ddr_gearbox_hold #(.WIDTH(WIDTH)) u_hold (
    .clk   (C),
    .rst   (R),
    .wr    (accept && (!load || hold_v)),
    .clr   (load && hold_v),
    .d     (D),
    .hold  (hold),
    .hold_v(hold_v)
  );
  always_comb begin
    state_n = (load && !avail) ? IDLE : SHIFT;
    sr_n    = !load ? sr >> 2 : hold_v ? hold : accept ? D : '0;
    cnt_n   = load ? '0 : cnt + CW'(1);
    und_n   = load && !avail && state == SHIFT;
  end
  always_ff @(posedge C)
    if (R) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      UNDERRUN <= 1'b0;
    end else begin
      state    <= state_n;
      sr       <= sr_n;
      cnt      <= cnt_n;
      UNDERRUN <= und_n;
    end
`ifdef O_DDR_GEARBOX_UNDERRUN_CNT_EN
  always_ff @(posedge C)
    if (R) UNDERRUN_CNT <= '0;
    else if (UNDERRUN && UNDERRUN_CNT != 8'hFF) UNDERRUN_CNT <= UNDERRUN_CNT + 8'd1;
`endif
endmodule

// File: tb/tb_o_ddr_gearbox.sv
// tb_o_ddr_gearbox: scoreboard bench for o_ddr_gearbox at WIDTH=8 and WIDTH=2
module tb_o_ddr_gearbox;
  logic       C = 1'b0;
  logic       R = 1'b1;
  logic [7:0] d8 = '0;
  logic       v8 = 1'b0;
  logic       rdy8, oe8, und8;
  logic [1:0] q8;
  logic [1:0] d2 = '0;
  logic       v2 = 1'b0;
  logic       rdy2, oe2, und2;
  logic [1:0] q2;
  logic [1:0] exp8[$];
  logic [1:0] exp2[$];
  int checks = 0;
  int errors = 0;
`ifdef O_DDR_GEARBOX_UNDERRUN_CNT_EN
  logic [7:0] ucnt8, ucnt2;
`endif
  always #5 C = ~C;
  o_ddr_gearbox #(.WIDTH(8)) u8 (
    .C(C), .R(R), .D(d8), .D_VALID(v8), .D_READY(rdy8), .Q(q8), .OE(oe8),
`ifdef O_DDR_GEARBOX_UNDERRUN_CNT_EN
    .UNDERRUN(und8), .UNDERRUN_CNT(ucnt8)
`else
    .UNDERRUN(und8)
`endif
  );
  o_ddr_gearbox #(.WIDTH(2)) u2 (
    .C(C), .R(R), .D(d2), .D_VALID(v2), .D_READY(rdy2), .Q(q2), .OE(oe2),
`ifdef O_DDR_GEARBOX_UNDERRUN_CNT_EN
    .UNDERRUN(und2), .UNDERRUN_CNT(ucnt2)
`else
    .UNDERRUN(und2)
`endif
  );
  always @(negedge C) begin
    if (oe8) begin
      checks++;
      if (exp8.size() == 0) begin
        errors++;
        $display("FAIL w8_unexpected_slice: OE=1 Q=%b with no word outstanding", q8);
      end else begin
        logic [1:0] e;
        e = exp8.pop_front();
        if (q8 !== e) begin
          errors++;
          $display("FAIL w8_slice: Q=%b expected %b", q8, e);
        end
      end
    end
    if (oe2) begin
      checks++;
      if (exp2.size() == 0) begin
        errors++;
        $display("FAIL w2_unexpected_slice: OE=1 Q=%b with no word outstanding", q2);
      end else begin
        logic [1:0] e;
        e = exp2.pop_front();
        if (q2 !== e) begin
          errors++;
          $display("FAIL w2_slice: Q=%b expected %b", q2, e);
        end
      end
    end
  end
  task automatic put8(input logic [7:0] w, output int stalls);
    int b;
    d8 = w;
    v8 = 1'b1;
    stalls = 0;
    b = 0;
    @(negedge C);
    while (rdy8 !== 1'b1 && b < 50) begin
      stalls++;
      b++;
      @(negedge C);
    end
    if (b >= 50) begin
      errors++;
      $display("FAIL put8_timeout: D_READY=%b after %0d cycles, required 1", rdy8, b);
    end
    @(posedge C);
    for (int i = 0; i < 4; i++) exp8.push_back(w[2*i +: 2]);
    #1;
  endtask
  task automatic test_reset();
    R = 1'b1;
    repeat (3) @(posedge C);
    @(negedge C);
    checks++;
    if ({q8, oe8, und8, rdy8} !== 5'b0) begin
      errors++;
      $display("FAIL reset_w8: Q/OE/UNDERRUN/D_READY=%b required 00000", {q8, oe8, und8, rdy8});
    end
    checks++;
    if ({q2, oe2, und2, rdy2} !== 5'b0) begin
      errors++;
      $display("FAIL reset_w2: Q/OE/UNDERRUN/D_READY=%b required 00000", {q2, oe2, und2, rdy2});
    end
    @(posedge C);
    #1 R = 1'b0;
    @(negedge C);
    checks++;
    if (rdy8 !== 1'b1 || rdy2 !== 1'b1 || oe8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: D_READY8=%b D_READY2=%b OE8=%b required 1 1 0", rdy8, rdy2, oe8);
    end
  endtask
  task automatic test_single();
    int s;
    @(posedge C);
    #1 put8(8'hB4, s);
    v8 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge C);
      checks++;
      if (oe8 !== 1'b1 || und8 !== 1'b0) begin
        errors++;
        $display("FAIL single_oe_slice%0d: OE=%b UNDERRUN=%b required 1 0", k, oe8, und8);
      end
    end
    @(negedge C);
    checks++;
    if (oe8 !== 1'b0 || q8 !== 2'b00 || und8 !== 1'b1) begin
      errors++;
      $display("FAIL single_underrun: OE=%b Q=%b UNDERRUN=%b required 0 00 1", oe8, q8, und8);
    end
    @(negedge C);
    checks++;
    if (und8 !== 1'b0) begin
      errors++;
      $display("FAIL single_underrun_pulse: UNDERRUN=%b required 0", und8);
    end
  endtask
  task automatic test_back_to_back();
    int s;
    @(posedge C);
    #1 put8(8'h1B, s);
    put8(8'hE4, s);
    checks++;
    if (s != 0) begin
      errors++;
      $display("FAIL b2b_second_accept: stalled %0d cycles, required 0", s);
    end
    v8 = 1'b0;
    for (int c = 1; c < 8; c++) begin
      @(negedge C);
      checks++;
      if (oe8 !== 1'b1 || rdy8 !== (c > 3)) begin
        errors++;
        $display("FAIL b2b_cycle%0d: OE=%b D_READY=%b required 1 %b", c, oe8, rdy8, c > 3);
      end
    end
    @(negedge C);
    checks++;
    if (oe8 !== 1'b0 || und8 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end: OE=%b UNDERRUN=%b required 0 1", oe8, und8);
    end
  endtask
  task automatic test_width2();
    logic [1:0] w[3] = '{2'b01, 2'b10, 2'b11};
    @(posedge C);
    #1 d2 = w[0];
    v2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge C);
      checks++;
      if (rdy2 !== 1'b1 || (i > 0 && oe2 !== 1'b1)) begin
        errors++;
        $display("FAIL w2_word%0d: D_READY=%b OE=%b required 1 %b", i, rdy2, oe2, i > 0);
      end
      @(posedge C);
      exp2.push_back(w[i]);
      #1;
      if (i < 2) d2 = w[i+1];
      else v2 = 1'b0;
    end
    @(negedge C);
    checks++;
    if (oe2 !== 1'b1 || und2 !== 1'b0) begin
      errors++;
      $display("FAIL w2_last: OE=%b UNDERRUN=%b required 1 0", oe2, und2);
    end
    @(negedge C);
    checks++;
    if (oe2 !== 1'b0 || und2 !== 1'b1) begin
      errors++;
      $display("FAIL w2_underrun: OE=%b UNDERRUN=%b required 0 1", oe2, und2);
    end
    @(negedge C);
    checks++;
    if (und2 !== 1'b0) begin
      errors++;
      $display("FAIL w2_underrun_pulse: UNDERRUN=%b required 0", und2);
    end
  endtask
  task automatic test_stall();
    int s, n;
    @(posedge C);
    #1 put8(8'h3C, s);
    put8(8'h96, s);
    put8(8'hA5, s);
    checks++;
    if (s != 3) begin
      errors++;
      $display("FAIL stall_cycles: stalled %0d cycles, required 3", s);
    end
    v8 = 1'b0;
    n = 0;
    @(negedge C);
    while (oe8 === 1'b1 && n < 30) begin
      n++;
      @(negedge C);
    end
    checks++;
    if (n != 7 || und8 !== 1'b1 || exp8.size() != 0) begin
      errors++;
      $display("FAIL stall_tail: OE cycles=%0d UNDERRUN=%b pending=%0d required 7 1 0", n, und8, exp8.size());
    end
  endtask
  task automatic test_reset_mid();
    int s;
    @(posedge C);
    #1 put8(8'h5A, s);
    put8(8'hC3, s);
    v8 = 1'b0;
    @(posedge C);
    #1 R = 1'b1;
    @(posedge C);
    #1 exp8.delete();
    @(negedge C);
    checks++;
    if ({q8, oe8, rdy8, und8} !== 5'b0) begin
      errors++;
      $display("FAIL midreset: Q/OE/D_READY/UNDERRUN=%b required 00000", {q8, oe8, rdy8, und8});
    end
    @(posedge C);
    #1 R = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge C);
      checks++;
      if (oe8 !== 1'b0 || und8 !== 1'b0 || q8 !== 2'b00 || rdy8 !== 1'b1) begin
        errors++;
        $display("FAIL midreset_after%0d: OE=%b UNDERRUN=%b Q=%b D_READY=%b required 0 0 00 1", c, oe8, und8, q8, rdy8);
      end
    end
  endtask
`ifdef O_DDR_GEARBOX_UNDERRUN_CNT_EN
  task automatic test_underrun_cnt();
    int s;
    @(posedge C);
    #1 R = 1'b1;
    @(posedge C);
    #1 R = 1'b0;
    exp8.delete();
    for (int i = 0; i < 300; i++) begin
      put8(8'(i), s);
      v8 = 1'b0;
      repeat (6) @(posedge C);
      #1;
    end
    @(negedge C);
    checks++;
    if (ucnt8 !== 8'hFF) begin
      errors++;
      $display("FAIL underrun_cnt: UNDERRUN_CNT=%h required ff", ucnt8);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_width2();
    test_stall();
    test_reset_mid();
`ifdef O_DDR_GEARBOX_UNDERRUN_CNT_EN
    test_underrun_cnt();
`endif
    repeat (3) @(negedge C);
    checks++;
    if (exp8.size() != 0 || exp2.size() != 0) begin
      errors++;
      $display("FAIL drain: pending slices w8=%0d w2=%0d required 0 0", exp8.size(), exp2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/o_ddr_gearbox.md
# o_ddr_gearbox

Parallel-to-2-bit output gearbox that sits directly upstream of the O_DDR output register. It accepts WIDTH-bit words over a valid/ready handshake and emits one 2-bit slice per clock on `Q[1:0]`, LSB slice first. `Q[1:0]` drives O_DDR `D[1:0]` and `OE` drives O_DDR `E`. A one-word holding register lets back-to-back words stream with no gap cycles.

## Interface
- `WIDTH`, default 8: parallel word width. Must be even, 2..16. N = WIDTH/2 slices per word.
- `C` input 1: clock, shared with the downstream O_DDR.
- `R` input 1: reset, synchronous, active-high.
- `D` input WIDTH: parallel data word.
- `D_VALID` input 1: `D` is valid.
- `D_READY` output 1: gearbox can accept a word this cycle.
- `Q` output 2: slice to O_DDR `D[1:0]`. `Q[0]` is the earlier-transmitted bit.
- `OE` output 1: slice valid; drives O_DDR `E`.
- `UNDERRUN` output 1: one-cycle pulse when an active stream runs dry.

## Operation
- Registers:
  - `sr[WIDTH-1:0]`: shift register.
  - `cnt`: slice index, 0..N-1.
  - `hold[WIDTH-1:0]` and `hold_v`: holding register and its valid flag.
  - `state`: IDLE or SHIFT.
- Outputs:
  - `Q = sr[1:0]` and `OE = (state==SHIFT)`; both come straight from flops.
  - `D_READY = !hold_v && !R`.
- Handshake: a word transfers when `D_VALID && D_READY` on a rising edge of `C`. `D` must be stable while `D_VALID` is high and `D_READY` is low.
- A "load" occurs when `state==IDLE`, or when `state==SHIFT && cnt==N-1`. On a load, the source is chosen in priority order:
  - `hold_v`: `sr<=hold`, `hold_v<=0`. A simultaneous accepted word goes into `hold`, so `hold_v` stays 1.
  - otherwise an accepted word: `sr<=D` (bypass).
  - otherwise, nothing available: next state is IDLE, `sr<=0`. If the state was SHIFT, `UNDERRUN` pulses on the next cycle.
- Every load sets `cnt<=0` and `state<=SHIFT`.
- Non-load SHIFT cycle: `sr<=sr>>2` with zero fill, `cnt<=cnt+1`. An accepted word goes into `hold`.
- IDLE: `Q=2'b00`, `OE=0`.
- WIDTH=2 (N=1): every SHIFT cycle is a load.
- Sustained throughput is one word per N cycles. `D_READY` is low only while `hold_v=1`.

## Timing
- Reset values: `Q=2'b00`, `OE=0`, `UNDERRUN=0`, `D_READY=0` while `R=1`, `D_READY=1` on the first cycle after reset releases. Internally `cnt=0`, `hold_v=0`, state IDLE.
- Latency: a word accepted in IDLE at edge t gives `OE=1`, `Q=D[1:0]` from t+1. Slice k appears at t+1+k.
- Back-to-back: with the next word already in `hold`, or accepted on the last-slice cycle, slice 0 of the next word follows slice N-1 with no gap and `OE` stays high.
- Underrun: the cycle after slice N-1 with no word available has `OE=0`, `Q=0`, `UNDERRUN=1`. `UNDERRUN` returns to 0 the following cycle.
- Reset mid-stream: all outputs reach reset values on the edge after `R` rises. The `hold` contents and any partial word are discarded. No `UNDERRUN` pulse is generated.
- A simultaneous accept and last-slice cycle with `hold_v=1` keeps `hold_v=1` and `D_READY=0`.

## Configuration
- `O_DDR_GEARBOX_UNDERRUN_CNT_EN`
- Defined: adds output `UNDERRUN_CNT[7:0]`.
  - Increments on each `UNDERRUN` pulse and saturates at 8'hFF.
  - Cleared by `R`.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `o_ddr_gearbox_pkg`:
  - state enum (IDLE, SHIFT).
  - `O_DDR_GEARBOX_MAX_WIDTH = 16`.
  - a `cnt` width function, `$clog2` of N with a minimum of 1.
- One sub-module, `o_ddr_gearbox_hold`: the one-word holding register with `hold_v`, write-on-accept and clear-on-load. The shift/count/state logic stays in the top.

## Test plan
- WIDTH=8, reset, single word 8'hB4:
  - `Q` = 2'b00, 2'b01, 2'b11, 2'b10 on cycles t+1..t+4 with `OE=1`.
  - Then `OE=0` and `UNDERRUN=1` at t+5.
- WIDTH=8, continuous `D_VALID` with words 8'h1B, 8'hE4:
  - `Q` stream is 11, 10, 01, 00, 00, 01, 10, 11.
  - `OE` stays high for 8 cycles with no gap.
  - `D_READY` drops for exactly the cycles where `hold_v=1`.
- WIDTH=2, words 2'b01, 2'b10, 2'b11 back-to-back: `Q` = 01, 10, 11 on consecutive cycles, then one `UNDERRUN` pulse.
- WIDTH=8, assert `R` during slice 2 of a word with `hold` full: next cycle `Q=0`, `OE=0`, `D_READY=0`, no `UNDERRUN`. After release, `D_READY=1` and no stale slices appear.
- WIDTH=8, `D_VALID` held high while `D_READY=0`: the word is accepted only when `D_READY` returns to 1. It is transmitted exactly once with no duplication.
- With `O_DDR_GEARBOX_UNDERRUN_CNT_EN` defined, 300 isolated single-word transfers give `UNDERRUN_CNT` = 8'hFF (saturated).
